// File: rtl/systolic_row_feeder_pkg.sv
// Shared definitions for the systolic array row feeder: state encoding,
// default geometry and counter sizing.
package systolic_row_feeder_pkg;

    localparam int ROWS_DEF       = 4;
    localparam int COLS_DEF       = 4;
    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_W  = 3'd1;
    localparam logic [2:0] S_SAVE    = 3'd2;
    localparam logic [2:0] S_COMPUTE = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_LOAD_W  = S_LOAD_W,
        ST_SAVE    = S_SAVE,
        ST_COMPUTE = S_COMPUTE,
        ST_DRAIN   = S_DRAIN
    } state_t;

    // Width of a counter that must be able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/systolic_row_feeder_if.sv
// Upstream beat stream into the row feeder: valid/ready handshake plus
// per-row operand vector and weight/last markers.
interface systolic_row_feeder_if
    import systolic_row_feeder_pkg::*;
#(
    parameter int ROWS       = ROWS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
    logic                       s_valid;
    logic                       s_ready;
    logic [ROWS*DATA_WIDTH-1:0] s_data;
    logic                       s_is_weight;
    logic                       s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_is_weight,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_is_weight,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/systolic_row_feeder_skew_delay_line.sv
// Fixed-depth shift register carrying {valid, data}; one instance per array
// row produces the diagonal skew.
module skew_delay_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH:0] stage_r [DEPTH];

    // Shift every cycle; an idle input cycle pushes a zero bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {(DATA_WIDTH + 1){1'b0}};
            end
        end else begin
            stage_r[0] <= {in_valid, in_data};
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_valid = stage_r[DEPTH-1][DATA_WIDTH];
    assign out_data  = stage_r[DEPTH-1][DATA_WIDTH-1:0];

endmodule

// File: rtl/systolic_row_feeder.sv
// Left-edge operand feeder for the weight-stationary systolic array: buffers a
// weight tile and replays it with save, then streams skewed feature vectors.
module systolic_row_feeder
    import systolic_row_feeder_pkg::*;
#(
    parameter int ROWS       = ROWS_DEF,
    parameter int COLS       = COLS_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rstn,
    systolic_row_feeder_if.slave       s_if,
    output logic [ROWS*DATA_WIDTH-1:0] a_out,
    output logic [ROWS-1:0]            en_out,
    output logic [ROWS-1:0]            save_out,
    output logic                       busy,
    output logic                       done
);

    localparam int VEC_W   = ROWS * DATA_WIDTH;
    localparam int CNT_MAX = (COLS > ROWS) ? COLS : ROWS;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int IDX_W   = (COLS > 1) ? $clog2(COLS) : 1;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               busy_r;
    logic               ready_r;
    logic               done_r;
    logic [VEC_W-1:0]   a_out_r;
    logic [ROWS-1:0]    en_out_r;
    logic [ROWS-1:0]    save_out_r;
    logic [VEC_W-1:0]   wbuf_r [COLS];

    logic               accept_s;
    logic               push_s;
    logic [VEC_W-1:0]   pipe_in_data_s;
    logic [VEC_W-1:0]   pipe_data_s;
    logic [ROWS-1:0]    pipe_valid_s;
    logic [IDX_W-1:0]   idx_s;

    assign accept_s = s_if.s_valid && ready_r;
    assign idx_s    = cnt_r[IDX_W-1:0];

    // Only feature beats enter the skew pipes; everything else becomes a bubble.
    always_comb begin
        push_s         = 1'b0;
        pipe_in_data_s = {VEC_W{1'b0}};
        case (state_r)
            ST_IDLE:    push_s = accept_s && !s_if.s_is_weight;
            ST_COMPUTE: push_s = accept_s;
            default:    push_s = 1'b0;
        endcase
        if (push_s) begin
            pipe_in_data_s = s_if.s_data;
        end else begin
            pipe_in_data_s = {VEC_W{1'b0}};
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_delay_line #(
            .DEPTH      (r + 1),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_skew (
            .clk       (clk),
            .rstn      (rstn),
            .in_valid  (push_s),
            .in_data   (pipe_in_data_s[r*DATA_WIDTH +: DATA_WIDTH]),
            .out_valid (pipe_valid_s[r]),
            .out_data  (pipe_data_s[r*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Control FSM, weight buffer and all array-facing output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
            a_out_r    <= {VEC_W{1'b0}};
            en_out_r   <= {ROWS{1'b0}};
            save_out_r <= {ROWS{1'b0}};
            for (int k = 0; k < COLS; k++) begin
                wbuf_r[k] <= {VEC_W{1'b0}};
            end
        end else begin
            // Pipe outputs flow through unless the weight replay overrides them;
            // the pipes are empty whenever SAVE is active.
            a_out_r    <= pipe_data_s;
            en_out_r   <= pipe_valid_s;
            save_out_r <= {ROWS{1'b0}};
            done_r     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && s_if.s_is_weight) begin
                        wbuf_r[0] <= s_if.s_data;
                        cnt_r     <= CNT_W'(1);
                        busy_r    <= 1'b1;
                        if (COLS == 1) begin
                            a_out_r    <= s_if.s_data;
                            save_out_r <= {ROWS{1'b1}};
                            state_r    <= ST_SAVE;
                            ready_r    <= 1'b0;
                        end else begin
                            state_r <= ST_LOAD_W;
                            ready_r <= 1'b1;
                        end
                    end else if (accept_s) begin
                        cnt_r  <= {CNT_W{1'b0}};
                        busy_r <= 1'b1;
                        if (s_if.s_last) begin
                            state_r <= ST_DRAIN;
                            ready_r <= 1'b0;
                        end else begin
                            state_r <= ST_COMPUTE;
                            ready_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ST_LOAD_W: begin
                    if (accept_s) begin
                        wbuf_r[idx_s] <= s_if.s_data;
                        if (cnt_r == CNT_W'(COLS - 1)) begin
                            a_out_r    <= wbuf_r[0];
                            save_out_r <= {ROWS{1'b1}};
                            cnt_r      <= CNT_W'(1);
                            state_r    <= ST_SAVE;
                            ready_r    <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_SAVE: begin
                    if (cnt_r == CNT_W'(COLS)) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        a_out_r    <= wbuf_r[idx_s];
                        save_out_r <= {ROWS{1'b1}};
                        cnt_r      <= cnt_r + CNT_W'(1);
                    end
                end
                ST_COMPUTE: begin
                    if (accept_s && s_if.s_last) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_DRAIN;
                        ready_r <= 1'b0;
                    end else begin
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ST_DRAIN: begin
                    // The last beat reaches the bottom row's output on the ROWS-th drain edge.
                    if (cnt_r == CNT_W'(ROWS - 1)) begin
                        done_r  <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        ready_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign s_if.s_ready = ready_r;
    assign a_out        = a_out_r;
    assign en_out       = en_out_r;
    assign save_out     = save_out_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule

// File: tb/tb_systolic_row_feeder.sv
// Directed self-checking bench for systolic_row_feeder (4 rows, 4 cols, 8-bit).
module tb_systolic_row_feeder;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;

    logic            clk;
    logic            rstn;
    logic [31:0]     a_out;
    logic [3:0]      en_out;
    logic [3:0]      save_out;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;

    logic [31:0] sl_data [16];
    bit          sl_valid[16];
    bit          sl_wt   [16];

    systolic_row_feeder_if #(.ROWS(ROWS), .DATA_WIDTH(DW)) s_if ();

    systolic_row_feeder #(.ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .s_if     (s_if),
        .a_out    (a_out),
        .en_out   (en_out),
        .save_out (save_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        s_if.s_valid     = 1'b0;
        s_if.s_is_weight = 1'b0;
        s_if.s_last      = 1'b0;
        s_if.s_data      = 32'hdead_beef;
    endtask

    task automatic load_weights(input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int k = 0; k < 4; k++) begin
            s_if.s_valid     = 1'b1;
            s_if.s_is_weight = (k == 0) ? 1'b1 : 1'b0;
            s_if.s_last      = (k == 2) ? 1'b1 : 1'b0;
            s_if.s_data      = w[k];
            step();
            if (k < 3) begin
                chk("load_busy", 64'(busy), 64'h1);
                chk("load_quiet", 64'({save_out, en_out, a_out}), 64'h0);
                idle_inputs();
                step();
                chk("load_gap_quiet", 64'({save_out, en_out, a_out}), 64'h0);
                chk("load_gap_ready", 64'(s_if.s_ready), 64'h1);
            end
        end
        idle_inputs();
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            chk("save_a", 64'(a_out), 64'(w[k]));
            chk("save_strobe", 64'(save_out), 64'hf);
            chk("save_en", 64'(en_out), 64'h0);
            chk("save_ready", 64'(s_if.s_ready), 64'h0);
        end
        step();
        chk("save_end", 64'({save_out, en_out, a_out}), 64'h0);
        chk("save_end_busy", 64'(busy), 64'h0);
        chk("save_end_ready", 64'(s_if.s_ready), 64'h1);
    endtask

    // Slot c drives one cycle; a valid slot is accepted at edge t0+c and row r
    // must show it at edge t0+c+1+r.
    task automatic run_stream(input int n, input string tag);
        logic [31:0] exp_a;
        logic [3:0]  exp_en;
        int          dones;
        dones = 0;
        for (int c = 0; c < n + ROWS + 2; c++) begin
            if (c < n) begin
                s_if.s_valid     = sl_valid[c];
                s_if.s_data      = sl_valid[c] ? sl_data[c] : 32'hdead_beef;
                s_if.s_is_weight = sl_wt[c];
                s_if.s_last      = (c == n - 1) ? 1'b1 : 1'b0;
            end else begin
                idle_inputs();
            end
            step();
            exp_a  = 32'h0;
            exp_en = 4'h0;
            for (int r = 0; r < ROWS; r++) begin
                int s;
                s = c - 1 - r;
                if (s >= 0 && s < n) begin
                    if (sl_valid[s]) begin
                        exp_en[r]        = 1'b1;
                        exp_a[r*DW +: DW] = sl_data[s][r*DW +: DW];
                    end
                end
            end
            chk({tag, "_a"}, 64'(a_out), 64'(exp_a));
            chk({tag, "_en"}, 64'(en_out), 64'(exp_en));
            chk({tag, "_save"}, 64'(save_out), 64'h0);
            chk({tag, "_done"}, 64'(done), (c == n - 1 + ROWS) ? 64'h1 : 64'h0);
            if (done === 1'b1) dones++;
        end
        chk({tag, "_done_count"}, 64'(dones), 64'h1);
        chk({tag, "_idle"}, 64'(busy), 64'h0);
    endtask

    initial begin
        rstn = 1'b0;
        idle_inputs();
        #12;
        chk("reset_outputs", 64'({save_out, en_out, a_out}), 64'h0);
        chk("reset_busy_done", 64'({busy, done}), 64'h0);
        rstn = 1'b1;
        step();
        chk("idle_ready", 64'(s_if.s_ready), 64'h1);

        // Weight tile with one idle cycle between beats.
        load_weights(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);

        // Single feature beat with last.
        sl_data[0] = 32'h0403_0201; sl_valid[0] = 1'b1; sl_wt[0] = 1'b0;
        run_stream(1, "single");

        // Six back-to-back beats.
        for (int j = 0; j < 6; j++) begin
            sl_data[j]  = {4{8'((j + 1) << 4)}} | 32'h0302_0100;
            sl_valid[j] = 1'b1;
            sl_wt[j]    = 1'b0;
        end
        run_stream(6, "burst");

        // Bubble in slot 3 and a weight-flagged beat in slot 4 during compute.
        for (int j = 0; j < 7; j++) begin
            sl_data[j]  = {4{8'(8'h80 + (j << 2))}} ^ 32'h0001_0203;
            sl_valid[j] = (j != 3);
            sl_wt[j]    = (j == 4);
        end
        run_stream(7, "bubble");

        // Reset while draining.
        s_if.s_valid = 1'b1; s_if.s_is_weight = 1'b0; s_if.s_last = 1'b1;
        s_if.s_data  = 32'h0a0b_0c0d;
        step();
        idle_inputs();
        step();
        chk("drain_pre_en", 64'(en_out), 64'h1);
        chk("drain_pre_a", 64'(a_out), 64'h0d);
        rstn = 1'b0;
        #2;
        chk("drain_rst_out", 64'({save_out, en_out, a_out}), 64'h0);
        chk("drain_rst_flags", 64'({busy, done, s_if.s_ready}), 64'h1);
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("drain_post", 64'({done, busy, save_out, en_out, a_out}), 64'h0);
        end

        // Reset part-way through a weight load.
        s_if.s_valid = 1'b1; s_if.s_is_weight = 1'b1; s_if.s_data = 32'h9999_9999;
        step();
        s_if.s_data = 32'haaaa_aaaa;
        step();
        idle_inputs();
        chk("loadw_pre_busy", 64'(busy), 64'h1);
        rstn = 1'b0;
        #2;
        chk("loadw_rst_out", 64'({save_out, en_out, a_out}), 64'h0);
        chk("loadw_rst_flags", 64'({busy, done, s_if.s_ready}), 64'h1);
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("loadw_post", 64'({done, busy, save_out, en_out, a_out}), 64'h0);
        end

        // Fresh load after the aborted one.
        load_weights(32'h5555_5555, 32'h6666_6666, 32'h7777_7777, 32'h8888_8888);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
